// File: rtl/multicycle_controller_pkg.sv
// Shared types for the HMMM multi-cycle controller: opcodes, FSM states,
// register-file write sources and the decoded opcode class bundle.
package hmmm_pkg;

    localparam int PCW = 8;
    localparam int IW  = 10;
    localparam int DW  = 4;

    typedef enum logic [3:0] {
        OP_HALT  = 4'b0000,
        OP_LOADN = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_LOAD  = 4'b0100,
        OP_STORE = 4'b0101,
        OP_JUMPN = 4'b1000,
        OP_JEQZN = 4'b1001
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_IMM = 2'b01,
        SRC_MEM = 2'b10
    } reg_src_t;

    typedef struct packed {
        logic is_alu;
        logic is_imm;
        logic is_mem;
        logic is_store;
        logic is_branch;
        logic is_cond;
        logic is_halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: opcode and flags in, strobes out.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           imem_ack;
    logic           dmem_ack;
    logic           imem_req;
    logic           ir_write;
    logic           pc_write;
    logic           pc_src;
    logic           reg_write;
    logic [1:0]     reg_src;
    logic           alu_sub;
    logic           dmem_req;
    logic           dmem_write;
    logic           halted;
    logic           illegal;
    logic [15:0]    retired;

    modport master (
        input  opcode, zero, imem_ack, dmem_ack,
        output imem_req, ir_write, pc_write, pc_src, reg_write, reg_src,
               alu_sub, dmem_req, dmem_write, halted, illegal, retired
    );

    modport slave (
        output opcode, zero, imem_ack, dmem_ack,
        input  imem_req, ir_write, pc_write, pc_src, reg_write, reg_src,
               alu_sub, dmem_req, dmem_write, halted, illegal, retired
    );

endinterface

// File: rtl/multicycle_controller_decode.sv
// Pure combinational opcode classifier; every undefined code is flagged
// illegal so the FSM can halt on it after DECODE.
module ctrl_decode
    import hmmm_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_HALT:  o_class.is_halt = 1'b1;
            OP_LOADN: o_class.is_imm  = 1'b1;
            OP_ADD,
            OP_SUB:   o_class.is_alu  = 1'b1;
            OP_LOAD:  o_class.is_mem  = 1'b1;
            OP_STORE: begin
                o_class.is_mem   = 1'b1;
                o_class.is_store = 1'b1;
            end
            OP_JUMPN: o_class.is_branch = 1'b1;
            OP_JEQZN: begin
                o_class.is_branch = 1'b1;
                o_class.is_cond   = 1'b1;
            end
            default:  o_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the 4-bit HMMM datapath.
// Define PERF_CNT_EN to build the retired-instruction counter.
module multicycle_controller
    import hmmm_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int TGTW = 6
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.master bus
);

    // The jump target is shifted left by two to form a full PC.
    if (OPW != 4 || TGTW + 2 != PCW || OPW + TGTW != IW) begin : g_bad_width
        $error("multicycle_controller: OPW/TGTW do not match the HMMM instruction format");
    end

    state_t    r_state;
    state_t    w_state_next;
    op_class_t w_class;
    logic      r_illegal;

    ctrl_decode u_decode (
        .i_opcode (bus.opcode),
        .o_class  (w_class)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_FETCH;
        else        r_state <= w_state_next;
    end

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        bus.imem_req   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_src    = SRC_ALU;
        bus.alu_sub    = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_write = 1'b0;
        bus.halted     = 1'b0;
        // Gating on reset kills imem_req while held in reset, even though the
        // state register already sits in FETCH.
        if (reset) begin
            case (r_state)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ack) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        w_state_next = ST_DECODE;
                    end
                end
                ST_DECODE: w_state_next = w_class.illegal ? ST_HALT : ST_EXEC;
                ST_EXEC: begin
                    if (w_class.is_alu) begin
                        bus.alu_sub  = bus.opcode[0];
                        w_state_next = ST_WB;
                    end else if (w_class.is_imm) begin
                        w_state_next = ST_WB;
                    end else if (w_class.is_mem) begin
                        w_state_next = ST_MEM;
                    end else if (w_class.is_branch) begin
                        if (!w_class.is_cond || bus.zero) begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = 1'b1;
                        end
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_HALT;
                    end
                end
                ST_MEM: begin
                    bus.dmem_req   = 1'b1;
                    bus.dmem_write = w_class.is_store;
                    if (bus.dmem_ack) w_state_next = w_class.is_store ? ST_FETCH : ST_WB;
                end
                ST_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_src   = w_class.is_alu ? SRC_ALU :
                                    w_class.is_imm ? SRC_IMM : SRC_MEM;
                    bus.alu_sub   = w_class.is_alu & bus.opcode[0];
                    w_state_next  = ST_FETCH;
                end
                ST_HALT:  bus.halted = 1'b1;
                default:  w_state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                         r_illegal <= 1'b0;
        else if (r_state == ST_DECODE && w_class.illegal)   r_illegal <= 1'b1;
    end

    assign bus.illegal = r_illegal;

`ifdef PERF_CNT_EN
    logic [15:0] r_retired;
    logic        w_retire;

    assign w_retire = (r_state inside {ST_EXEC, ST_MEM, ST_WB}) && (w_state_next == ST_FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + 16'd1;
    end

    assign bus.retired = r_retired;
`else
    assign bus.retired = '0;
`endif

endmodule
